mux_scan_sequencer: RTL and testbench
=====================================

Name: mux_scan_sequencer

Overview:
Upstream controller for the 16:1 single-bit multiplexer.
- Drives the mux select and steps through the enabled channels.
- Samples the mux output once per channel, after a programmable settle time.
- Assembles the samples into a 16-bit capture word, delivered on a valid/ready output interface.
- Sits between the control logic (start/abort) and the combinational mux.

Parameters:
- N_CH, 16: number of mux channels. Fixed at 16 for this revision.
- SEL_W, 4: select width, log2(N_CH).
- SETTLE_CYCLES, 1: idle cycles between a select change and the sample. Range 0..15. 0 means the sample happens on the cycle after the select update.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: request a scan. Sampled on a rising clk edge.
- abort, input, 1: synchronous cancel of any scan or pending result.
- scan_mask, input, 16: channel enables. Latched when start is accepted.
- mux_sel, output, SEL_W: select driven to the mux.
- mux_out, input, 1: single-bit output of the mux, combinational from mux_sel.
- busy, output, 1: high in SETTLE and SAMPLE.
- dout, output, 16: capture word. Bit k is the sample of channel k; masked channels read 0.
- dout_valid, output, 1: capture word available.
- dout_ready, input, 1: consumer accepts dout.

Behaviour:
- Reset (async assert, sync release): state IDLE, mux_sel=0, dout=16'h0000, dout_valid=0, busy=0, mask register=0, settle counter=0.
- States: IDLE, SETTLE, SAMPLE, OUTPUT.
- Start acceptance:
  - start is accepted in IDLE, or in OUTPUT on the same edge that dout_ready completes the handshake.
  - start is ignored in SETTLE and SAMPLE.
- On accept at edge E0:
  - latch scan_mask and clear the capture register.
  - If mask==0: go to OUTPUT, dout=0.
  - Otherwise: mux_sel = lowest set mask bit, settle counter = SETTLE_CYCLES, next state SETTLE (or SAMPLE if SETTLE_CYCLES==0).
- SETTLE: the counter decrements each cycle. On the edge where it reaches 0, go to SAMPLE.
- SAMPLE (exactly one cycle):
  - on the edge, capture[mux_sel] <= mux_out.
  - If another set mask bit exists above mux_sel: mux_sel = that bit, reload the counter, go to SETTLE (or stay in SAMPLE if SETTLE_CYCLES==0).
  - Else: go to OUTPUT.
  - dout is updated from the capture register on entry to OUTPUT.
- Channel handling: masked channels are never selected. mux_sel holds its last value after the final sample and through OUTPUT.
- Latency: with N = popcount(mask) and S = SETTLE_CYCLES, dout_valid rises at edge E0 + N*(S+1). A full mask with S=1 takes 32 cycles; mask==0 gives valid at E0.
- OUTPUT:
  - dout_valid=1; dout and dout_valid stay stable until dout_ready is high on an edge.
  - That edge goes to IDLE, or starts a new scan if start is also high.
  - dout keeps its last value after the handshake. Only dout_valid drops.
- abort (priority over start and the handshake):
  - any state goes to IDLE on the next edge: dout_valid=0, busy=0, mux_sel=0.
  - partial capture is discarded; dout is not updated.
- Reset mid-scan: immediate return to reset values, no output produced.
- mux_sel only changes on clk edges, so the settle time is exactly S full cycles plus the sample cycle.

Decomposition:
- Package mux_scan_pkg holds:
  - state enum (IDLE, SETTLE, SAMPLE, OUTPUT)
  - N_CH and SEL_W localparams
  - settle counter width constant (4).
- One sub-module: next_chan_find, combinational. Inputs: mask[15:0] and cur_sel[3:0]. Outputs: the next set bit strictly above cur_sel, plus a found flag. The same module supplies the first channel when its "include cur" input is set with cur_sel=0.

Test Plan:
- Full scan: mux model inputs 16'h3f0a, mask 16'hFFFF, S=1, start at E0, dout_ready held high → dout_valid at E0+32, dout=16'h3f0a, mux_sel visits 0..15 in order, each value held 2 cycles.
- Sparse mask: inputs 16'h3f0a, mask 16'h0F00 → mux_sel visits only 8,9,10,11; dout=16'h0F00; valid at E0+8.
- Empty mask: mask 16'h0000 → dout_valid=1 and dout=0 on edge E0; busy never asserts.
- Backpressure with back-to-back scans: dout_ready low for 10 cycles in OUTPUT → dout stable, dout_valid held, start pulses ignored. Then dout_ready=1 with start=1 and mask 16'h0001 on the same edge → new scan begins immediately, and the second result equals bit 0 of the inputs.
- Abort: abort asserted when mux_sel=5 during a full scan → next edge IDLE, busy=0, mux_sel=0, dout_valid never rises, dout keeps its previous value.
- Reset mid-scan: rst_n low asynchronously mid-SETTLE → outputs go to reset values without a clock edge. After release, a new full scan completes normally.

Source files
------------

// File: rtl/mux_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mux_scan_pkg
//  Brief    : Shared types and constants for the mux scan sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package mux_scan_pkg;

  // Number of mux channels and the matching select width
  localparam int N_CH  = 16;
  localparam int SEL_W = 4;

  // Width of the settle-time down-counter (covers 0..15 idle cycles)
  localparam int CNT_W = 4;

  // Scan sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_OUTPUT = 2'd3
  } state_t;

endpackage : mux_scan_pkg
`default_nettype wire

// File: rtl/mux_scan_sequencer_next_chan_find.sv
`default_nettype none
// ============================================================================
//  Module   : next_chan_find
//  Brief    : Finds the lowest enabled channel strictly above the current
//             select, or at/above it when i_incl_cur is set. Purely
//             combinational.
//  Revision : 1.0 - initial release
// ============================================================================
module next_chan_find
  import mux_scan_pkg::*;
(
  input  logic [N_CH-1:0]  i_mask,
  input  logic [SEL_W-1:0] i_cur_sel,
  input  logic             i_incl_cur,
  output logic [SEL_W-1:0] o_next_sel,
  output logic             o_found
);

  // Walk from the top channel down so the last qualifying hit is the lowest
  always_comb begin
    o_next_sel = '0;
    o_found    = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (i_mask[i] && ((i > int'(i_cur_sel)) ||
                        (i_incl_cur && (i == int'(i_cur_sel))))) begin
        o_next_sel = SEL_W'(i);
        o_found    = 1'b1;
      end
    end
  end

endmodule : next_chan_find
`default_nettype wire

// File: rtl/mux_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mux_scan_sequencer
//  Brief    : Steps a 16:1 single-bit mux through the enabled channels,
//             samples each after a programmable settle time and delivers
//             the assembled capture word on a valid/ready interface.
//  Revision : 1.0 - initial release
// ============================================================================
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [N_CH-1:0]  scan_mask,
  output logic [SEL_W-1:0] mux_sel,
  input  logic             mux_out,
  output logic             busy,
  output logic [N_CH-1:0]  dout,
  output logic             dout_valid,
  input  logic             dout_ready
);

  // Counter reload value and the state a freshly selected channel enters
  localparam logic [CNT_W-1:0] c_settle     = CNT_W'(SETTLE_CYCLES);
  localparam state_t           c_chan_state = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;

  state_t           r_state;
  logic [N_CH-1:0]  r_mask;
  logic [N_CH-1:0]  r_cap;
  logic [CNT_W-1:0] r_cnt;
  logic [SEL_W-1:0] r_sel;
  logic [N_CH-1:0]  r_dout;
  logic             r_valid;
  logic             r_busy;

  logic             w_accept;
  logic [SEL_W-1:0] w_first_sel;
  logic             w_first_found;
  logic [SEL_W-1:0] w_next_sel;
  logic             w_next_found;
  logic [N_CH-1:0]  w_cap_next;

  // First channel of a new scan, taken straight from the incoming mask
  next_chan_find u_first_find (
    .i_mask     (scan_mask),
    .i_cur_sel  ({SEL_W{1'b0}}),
    .i_incl_cur (1'b1),
    .o_next_sel (w_first_sel),
    .o_found    (w_first_found)
  );

  // Next channel above the one currently being sampled
  next_chan_find u_next_find (
    .i_mask     (r_mask),
    .i_cur_sel  (r_sel),
    .i_incl_cur (1'b0),
    .o_next_sel (w_next_sel),
    .o_found    (w_next_found)
  );

  // A scan starts from IDLE, or from OUTPUT on the handshake edge
  assign w_accept = start && ((r_state == ST_IDLE) ||
                              ((r_state == ST_OUTPUT) && dout_ready));

  // Capture word including the bit being sampled this cycle
  always_comb begin
    w_cap_next        = r_cap;
    w_cap_next[r_sel] = mux_out;
  end

  // Scan state machine with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_mask  <= '0;
      r_cap   <= '0;
      r_cnt   <= '0;
      r_sel   <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else if (abort) begin
      // Cancel wins over everything; partial capture is dropped, dout kept
      r_state <= ST_IDLE;
      r_cap   <= '0;
      r_cnt   <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else if (w_accept) begin
      r_mask <= scan_mask;
      r_cap  <= '0;
      if (!w_first_found) begin
        // Empty mask: result is immediately available and all-zero
        r_state <= ST_OUTPUT;
        r_dout  <= '0;
        r_valid <= 1'b1;
        r_busy  <= 1'b0;
      end else begin
        r_state <= c_chan_state;
        r_sel   <= w_first_sel;
        r_cnt   <= c_settle;
        r_valid <= 1'b0;
        r_busy  <= 1'b1;
      end
    end else begin
      case (r_state)
        ST_SETTLE: begin
          if (r_cnt <= CNT_W'(1)) begin
            r_cnt   <= '0;
            r_state <= ST_SAMPLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_SAMPLE: begin
          r_cap <= w_cap_next;
          if (w_next_found) begin
            r_sel   <= w_next_sel;
            r_cnt   <= c_settle;
            r_state <= c_chan_state;
          end else begin
            // Last channel: publish the word, select holds its final value
            r_state <= ST_OUTPUT;
            r_dout  <= w_cap_next;
            r_valid <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        ST_OUTPUT: begin
          if (dout_ready) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mux_sel    = r_sel;
  assign busy       = r_busy;
  assign dout       = r_dout;
  assign dout_valid = r_valid;

endmodule : mux_scan_sequencer
`default_nettype wire

// File: tb/tb_mux_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_scan_sequencer
//  Brief    : Self-checking bench for mux_scan_sequencer with a behavioural
//             mux and a reference model derived from the scan rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux_scan_sequencer;

  localparam int S = 1;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b0;
  logic        start      = 1'b0;
  logic        abort      = 1'b0;
  logic [15:0] scan_mask  = 16'h0000;
  logic [3:0]  mux_sel;
  logic        mux_out;
  logic        busy;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready = 1'b0;

  logic [15:0] r_x        = 16'h0000;  // per-channel mux input levels
  logic [15:0] last_dout  = 16'h0000;  // model of the published word
  int          n_cmp      = 0;
  int          n_bad      = 0;

  always #5 clk = ~clk;

  // Behavioural 16:1 mux
  assign mux_out = r_x[mux_sel];

  mux_scan_sequencer #(.SETTLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .scan_mask  (scan_mask),
    .mux_sel    (mux_sel),
    .mux_out    (mux_out),
    .busy       (busy),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after the accept edge; follows the scan to the valid edge
  task automatic scan_body(input logic [15:0] m);
    int ch[$];
    int len;
    for (int b = 0; b < 16; b++)
      if (m[b]) ch.push_back(b);
    len = ch.size() * (S + 1);
    for (int k = 0; k < len; k++) begin
      check_eq("scan_valid", dout_valid, 0);
      check_eq("scan_busy", busy, 1);
      check_eq("scan_sel", mux_sel, ch[k / (S + 1)]);
      check_eq("scan_dout_hold", dout, last_dout);
      start      = 1'($urandom_range(0, 1));
      dout_ready = 1'($urandom_range(0, 1));
      scan_mask  = 16'($urandom);
      step();
    end
    start = 1'b0;
    check_eq("out_valid", dout_valid, 1);
    check_eq("out_busy", busy, 0);
    check_eq("out_dout", dout, r_x & m);
    if (ch.size() > 0)
      check_eq("out_sel_hold", mux_sel, ch[ch.size() - 1]);
    last_dout = r_x & m;
  endtask

  task automatic launch(input logic [15:0] m);
    start     = 1'b1;
    scan_mask = m;
    step();
    start     = 1'b0;
    scan_body(m);
  endtask

  // Backpressure: result must stay put and start pulses must be ignored
  task automatic hold_output(input int hold);
    dout_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      start     = 1'($urandom_range(0, 1));
      scan_mask = 16'($urandom);
      step();
      check_eq("hold_valid", dout_valid, 1);
      check_eq("hold_busy", busy, 0);
      check_eq("hold_dout", dout, last_dout);
    end
    start = 1'b0;
  endtask

  task automatic release_out();
    dout_ready = 1'b1;
    start      = 1'b0;
    step();
    check_eq("rel_valid", dout_valid, 0);
    check_eq("rel_busy", busy, 0);
    check_eq("rel_dout", dout, last_dout);
    dout_ready = 1'b0;
  endtask

  task automatic chain(input logic [15:0] m);
    dout_ready = 1'b1;
    start      = 1'b1;
    scan_mask  = m;
    step();
    start      = 1'b0;
    scan_body(m);
  endtask

  initial begin
    logic        seen;
    logic        in_output;
    logic [15:0] m;
    int          waited;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_sel", mux_sel, 0);
    check_eq("rst_dout", dout, 0);
    check_eq("rst_valid", dout_valid, 0);
    check_eq("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Full scan
    r_x = 16'h3f0a;
    launch(16'hFFFF);
    release_out();

    // Sparse mask
    launch(16'h0F00);
    release_out();

    // Empty mask: valid on the accept edge, never busy
    launch(16'h0000);
    release_out();

    // Backpressure then back-to-back scan of channel 0
    launch(16'hFFFF);
    hold_output(10);
    chain(16'h0001);
    release_out();

    // Abort when the scan reaches channel 5
    r_x       = 16'($urandom);
    start     = 1'b1;
    scan_mask = 16'hFFFF;
    step();
    start  = 1'b0;
    waited = 0;
    while (mux_sel != 4'd5 && waited < 100) begin
      step();
      waited++;
    end
    check_eq("abort_reach_sel5", mux_sel, 5);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_sel", mux_sel, 0);
    check_eq("abort_valid", dout_valid, 0);
    check_eq("abort_dout", dout, last_dout);
    seen = 1'b0;
    repeat (40) begin
      step();
      seen = seen | dout_valid;
    end
    check_eq("abort_no_valid", seen, 0);

    // Asynchronous reset in the middle of SETTLE
    r_x       = 16'($urandom);
    start     = 1'b1;
    scan_mask = 16'hFFFF;
    step();
    start = 1'b0;
    step();
    step();
    check_eq("pre_rst_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_sel", mux_sel, 0);
    check_eq("async_rst_busy", busy, 0);
    check_eq("async_rst_valid", dout_valid, 0);
    check_eq("async_rst_dout", dout, 0);
    last_dout = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    r_x = 16'($urandom);
    launch(16'hFFFF);
    release_out();

    // Randomized scans, mixing releases and back-to-back chaining
    in_output = 1'b0;
    for (int it = 0; it < 30; it++) begin
      r_x = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       m = 16'h0000;
        1:       m = 16'($urandom) & 16'($urandom) & 16'($urandom);
        default: m = 16'($urandom);
      endcase
      if (in_output && ($urandom_range(0, 1) == 1)) begin
        chain(m);
      end else begin
        if (in_output) release_out();
        launch(m);
      end
      hold_output(int'($urandom_range(0, 3)));
      in_output = 1'b1;
    end
    release_out();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_mux_scan_sequencer
`default_nettype wire
